monster_spawner: RTL and testbench

//  Game-side controller that drives the monster's control inputs (gene, hit, beat_monster).

---
 rtl/monster_pkg.sv | 32 +++
 rtl/spawn_lfsr.sv | 28 ++
 rtl/monster_spawner.sv | 181 ++++++++++++++++++
 tb/tb_monster_spawner.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/monster_pkg.sv
// Shared types and constants for the monster spawn controller.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package monster_pkg;

   typedef enum logic [2:0] {
      WAIT    = 3'd0,
      SPAWN   = 3'd1,
      LIVE    = 3'd2,
      RESOLVE = 3'd3
   } spawn_state_t;

   typedef logic [9:0] coord_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   localparam coord_t      MIN_GAP_D   = 10'd120;
   localparam coord_t      GAP_MASK_D  = 10'd127;
   localparam logic [3:0]  SPAWN_TMO_D = 4'd3;
   localparam coord_t      DOODLER_W_D = 10'd40;
   localparam coord_t      DOODLER_H_D = 10'd40;
   localparam coord_t      STOMP_TOL_D = 10'd8;
   localparam logic [15:0] LFSR_SEED_D = 16'hACE1;

   // Frames until the next spawn; 10-bit wrap is accepted for odd parameter choices.
   function automatic coord_t gap_reload(input coord_t min_gap, input coord_t mask,
                                         input logic [15:0] lfsr);
      return min_gap + (lfsr[9:0] & mask);
   endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to randomise spawn gaps.
// Latency: o_q updates one i_clk after i_en; seed loads on synchronous reset.
// Backpressure: none; i_en simply holds the sequence.
// Ports: i_clk, i_reset (sync, active-high), i_en (step), i_seed (reset value,
//        must be non-zero), o_q (current register value).
module spawn_lfsr (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_en,
   input  logic [15:0] i_seed,
   output logic [15:0] o_q
);

   logic [15:0] r_q;
   logic        w_fb;

   assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];
   assign o_q  = r_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_q <= i_seed;
      end else if (i_en) begin
         r_q <= {r_q[14:0], w_fb};
      end
   end

endmodule

// File: rtl/monster_spawner.sv
// Schedules monster spawns and resolves doodler/monster collisions as frame pulses.
// Latency: all decisions taken on the Clk after a frame_clk rising edge; pulses last one frame.
// Backpressure: none; frames are never stalled, game_active only freezes the spawn gap.
// Ports: Clk, Reset (sync, active-high), frame_clk (frame strobe level), game_active,
//        appear / Monster_X,Y,S (monster status), Doodler_X,Y, doodler_falling,
//        gene / hit / beat_monster (frame pulses to monster), state_dbg (FSM state).
// Build option: define MONSTER_STOMP_EN to let a falling doodler landing on the
//        monster's top band kill it (beat_monster); otherwise every overlap is a hit.
module monster_spawner
   import monster_pkg::*;
#(
   parameter coord_t      MIN_GAP   = MIN_GAP_D,
   parameter coord_t      GAP_MASK  = GAP_MASK_D,
   parameter logic [3:0]  SPAWN_TMO = SPAWN_TMO_D,
   parameter coord_t      DOODLER_W = DOODLER_W_D,
   parameter coord_t      DOODLER_H = DOODLER_H_D,
   parameter coord_t      STOMP_TOL = STOMP_TOL_D,
   parameter logic [15:0] LFSR_SEED = LFSR_SEED_D
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       game_active,
   input  logic       appear,
   input  coord_t     Monster_X,
   input  coord_t     Monster_Y,
   input  coord_t     Monster_S,
   input  coord_t     Doodler_X,
   input  coord_t     Doodler_Y,
   input  logic       doodler_falling,
   output logic       gene,
   output logic       hit,
   output logic       beat_monster,
   output logic [2:0] state_dbg
);

   spawn_state_t r_state, w_state_nxt;
   coord_t       r_gap, w_gap_nxt;
   logic [3:0]   r_tmo, w_tmo_nxt;
   logic         r_seen, w_seen_nxt;     // monster has been visible since this spawn
   logic         r_gene, w_gene_nxt;
   logic         r_hit, w_hit_nxt;
   logic         r_beat, w_beat_nxt;
   logic         r_frame_q;

   logic         w_tick;
   logic [15:0]  w_lfsr;
   coord_t       w_reload;

   // Far edges as 11-bit sums so nothing near the 10-bit limit wraps.
   logic [10:0]  w_mx_far, w_my_far, w_dx_far, w_dy_far, w_band_low;
   logic         w_overlap, w_stomp_band, w_stomp;

   assign w_tick = frame_clk & ~r_frame_q;

   spawn_lfsr u_lfsr (
      .i_clk   (Clk),
      .i_reset (Reset),
      .i_en    (w_tick),
      .i_seed  (LFSR_SEED),
      .o_q     (w_lfsr)
   );

   assign w_reload = gap_reload(MIN_GAP, GAP_MASK, w_lfsr);

   assign w_mx_far   = {1'b0, Monster_X} + {Monster_S, 1'b0};
   assign w_my_far   = {1'b0, Monster_Y} + {Monster_S, 1'b0};
   assign w_dx_far   = {1'b0, Doodler_X} + {1'b0, DOODLER_W} - 11'd1;
   assign w_dy_far   = {1'b0, Doodler_Y} + {1'b0, DOODLER_H} - 11'd1;
   assign w_band_low = {1'b0, Monster_Y} + {1'b0, STOMP_TOL} - 11'd1;

   assign w_overlap = ({1'b0, Doodler_X} <= w_mx_far) && (w_dx_far >= {1'b0, Monster_X}) &&
                      ({1'b0, Doodler_Y} <= w_my_far) && (w_dy_far >= {1'b0, Monster_Y});

   // Doodler's feet land inside the top STOMP_TOL rows of the monster while falling.
   assign w_stomp_band = doodler_falling && (w_dy_far >= {1'b0, Monster_Y}) &&
                         (w_dy_far <= w_band_low);

`ifdef MONSTER_STOMP_EN
   assign w_stomp      = w_stomp_band;
   assign beat_monster = r_beat;
`else
   logic w_unused_stomp;
   assign w_stomp        = 1'b0;
   assign beat_monster   = 1'b0;
   assign w_unused_stomp = &{1'b0, w_stomp_band, r_beat};
`endif

   logic w_unused_lfsr;
   assign w_unused_lfsr = &{1'b0, w_lfsr[15:10]};

   assign gene      = r_gene;
   assign hit       = r_hit;
   assign state_dbg = r_state;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= WAIT;
         r_gap     <= MIN_GAP;
         r_tmo     <= '0;
         r_seen    <= 1'b0;
         r_gene    <= 1'b0;
         r_hit     <= 1'b0;
         r_beat    <= 1'b0;
         r_frame_q <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_gap     <= w_gap_nxt;
         r_tmo     <= w_tmo_nxt;
         r_seen    <= w_seen_nxt;
         r_gene    <= w_gene_nxt;
         r_hit     <= w_hit_nxt;
         r_beat    <= w_beat_nxt;
         r_frame_q <= frame_clk;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap;
      w_tmo_nxt   = r_tmo;
      w_seen_nxt  = r_seen;
      w_gene_nxt  = r_gene;
      w_hit_nxt   = r_hit;
      w_beat_nxt  = r_beat;
      if (w_tick) begin
         // Every pulse is cleared on the tick after it was raised.
         w_gene_nxt = 1'b0;
         w_hit_nxt  = 1'b0;
         w_beat_nxt = 1'b0;
         case (r_state)
            WAIT: begin
               if (game_active) begin
                  // Spawn on the tick that would take the gap to zero.
                  if (r_gap <= 10'd1) begin
                     w_gap_nxt   = '0;
                     w_gene_nxt  = 1'b1;
                     w_state_nxt = SPAWN;
                  end else begin
                     w_gap_nxt = r_gap - 10'd1;
                  end
               end
            end
            SPAWN: begin
               w_tmo_nxt   = SPAWN_TMO;
               w_seen_nxt  = 1'b0;
               w_state_nxt = LIVE;
            end
            LIVE: begin
               if (appear) begin
                  w_seen_nxt = 1'b1;
                  if (w_overlap) begin
                     w_state_nxt = RESOLVE;
                     if (w_stomp) w_beat_nxt = 1'b1;
                     else         w_hit_nxt  = 1'b1;
                  end
               end else if (r_seen) begin
                  // Monster left the screen.
                  w_gap_nxt   = w_reload;
                  w_state_nxt = WAIT;
               end else if (r_tmo <= 4'd1) begin
                  // Monster never showed up; abandon this spawn.
                  w_gap_nxt   = w_reload;
                  w_state_nxt = WAIT;
               end else begin
                  w_tmo_nxt = r_tmo - 4'd1;
               end
            end
            RESOLVE: begin
               w_gap_nxt   = w_reload;
               w_state_nxt = WAIT;
            end
            default: begin
               w_gap_nxt   = w_reload;
               w_state_nxt = WAIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_monster_spawner.sv
// Directed bench for monster_spawner: spawn timing, collision classes, timeout, stall, reset.
// Latency: each frame tick is two Clk cycles (frame_clk high one cycle, low one cycle).
// Backpressure: n/a.
module tb_monster_spawner;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_clk = 1'b0;
   logic       game_active = 1'b1;
   logic       appear = 1'b0;
   logic [9:0] Monster_X = 10'd200, Monster_Y = 10'd200, Monster_S = 10'd19;
   logic [9:0] Doodler_X = 10'd500, Doodler_Y = 10'd400;
   logic       doodler_falling = 1'b0;
   logic       gene, hit, beat_monster;
   logic [2:0] state_dbg;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] m_lfsr = 16'hACE1;
   logic [15:0] m_prev = 16'hACE1;

   monster_spawner dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .frame_clk       (frame_clk),
      .game_active     (game_active),
      .appear          (appear),
      .Monster_X       (Monster_X),
      .Monster_Y       (Monster_Y),
      .Monster_S       (Monster_S),
      .Doodler_X       (Doodler_X),
      .Doodler_Y       (Doodler_Y),
      .doodler_falling (doodler_falling),
      .gene            (gene),
      .hit             (hit),
      .beat_monster    (beat_monster),
      .state_dbg       (state_dbg)
   );

   always #5 Clk = ~Clk;

   function automatic logic [15:0] lfsr_nxt(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic int gap_of(input logic [15:0] l);
      logic [9:0] low;
      low = l[9:0] & 10'd127;
      return 120 + int'(low);
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One frame tick; returns at a negedge with the post-tick outputs settled.
   task automatic do_tick();
      @(negedge Clk) frame_clk = 1'b1;
      @(negedge Clk) frame_clk = 1'b0;
      m_prev = m_lfsr;
      m_lfsr = lfsr_nxt(m_lfsr);
   endtask

   task automatic run_to_gene(input int max, output int idx);
      idx = 0;
      for (int i = 1; i <= max; i++) begin
         do_tick();
         if (gene === 1'b1) begin
            idx = i;
            break;
         end
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      m_lfsr = 16'hACE1;
      m_prev = 16'hACE1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int g;
      logic exp_hit2, exp_beat2;

      // ---- 1: reset state and first spawn after MIN_GAP frames ----
      do_reset();
      chk("rst_state", state_dbg, 16'd0);
      chk("rst_gene", gene, 16'd0);
      chk("rst_hit", hit, 16'd0);
      chk("rst_beat", beat_monster, 16'd0);
      run_to_gene(130, idx);
      chk("first_gap", idx, 16'd120);
      chk("spawn_state", state_dbg, 16'd1);
      do_tick();
      chk("gene_one_frame", gene, 16'd0);
      chk("live_state", state_dbg, 16'd2);
      chk("live_hit0", hit, 16'd0);
      chk("live_beat0", beat_monster, 16'd0);

      // ---- 2a: overlap below the stomp band -> hit ----
      appear = 1'b1; doodler_falling = 1'b1;
      Doodler_X = 10'd210; Doodler_Y = 10'd170;
      do_tick();
      chk("hit_side", hit, 16'd1);
      chk("hit_side_beat", beat_monster, 16'd0);
      chk("resolve_state", state_dbg, 16'd3);
      appear = 1'b0; Doodler_X = 10'd500; Doodler_Y = 10'd400;
      do_tick();
      chk("hit_cleared", hit, 16'd0);
      chk("resolve_to_wait", state_dbg, 16'd0);
      g = gap_of(m_prev);
      run_to_gene(g + 5, idx);
      chk("gap_after_hit", idx, 16'(g));

      // ---- 2b: feet in the stomp band ----
      do_tick();
      appear = 1'b1; Doodler_X = 10'd210; Doodler_Y = 10'd163;
`ifdef MONSTER_STOMP_EN
      exp_hit2 = 1'b0; exp_beat2 = 1'b1;
`else
      exp_hit2 = 1'b1; exp_beat2 = 1'b0;
`endif
      do_tick();
      chk("stomp_hit", hit, 16'(exp_hit2));
      chk("stomp_beat", beat_monster, 16'(exp_beat2));
      appear = 1'b0; Doodler_X = 10'd500; Doodler_Y = 10'd400; doodler_falling = 1'b0;
      do_tick();
      chk("stomp_cleared", beat_monster, 16'd0);
      g = gap_of(m_prev);
      run_to_gene(g + 5, idx);
      chk("gap_after_stomp", idx, 16'(g));

      // ---- 3: inclusive left edge ----
      do_tick();
      appear = 1'b1; Doodler_X = 10'd160; Doodler_Y = 10'd200;
      do_tick();
      chk("edge_miss_hit", hit, 16'd0);
      chk("edge_miss_state", state_dbg, 16'd2);
      Doodler_X = 10'd161;
      do_tick();
      chk("edge_touch_hit", hit, 16'd1);
      appear = 1'b0; Doodler_X = 10'd500; Doodler_Y = 10'd400;
      do_tick();
      g = gap_of(m_prev);
      run_to_gene(g + 5, idx);
      chk("gap_after_edge", idx, 16'(g));

      // ---- 5a: monster leaves screen without contact ----
      do_tick();
      appear = 1'b1;
      do_tick();
      chk("far_no_hit", hit, 16'd0);
      chk("far_live", state_dbg, 16'd2);
      appear = 1'b0;
      do_tick();
      chk("exit_state", state_dbg, 16'd0);
      chk("exit_hit", hit, 16'd0);
      chk("exit_beat", beat_monster, 16'd0);
      g = gap_of(m_prev);
      run_to_gene(g + 5, idx);
      chk("gap_after_exit", idx, 16'(g));

      // ---- 4: appear never rises -> abandon after SPAWN_TMO frames ----
      do_tick();
      chk("tmo_live0", state_dbg, 16'd2);
      do_tick();
      do_tick();
      chk("tmo_live2", state_dbg, 16'd2);
      do_tick();
      chk("tmo_wait", state_dbg, 16'd0);
      chk("tmo_hit", hit, 16'd0);
      chk("tmo_beat", beat_monster, 16'd0);
      g = gap_of(m_prev);

      // ---- 6: 50 stalled frames push the next spawn out by 50 ----
      game_active = 1'b0;
      run_to_gene(50, idx);
      chk("stall_no_gene", idx, 16'd0);
      chk("stall_state", state_dbg, 16'd0);
      game_active = 1'b1;
      run_to_gene(g + 5, idx);
      chk("gap_after_stall", idx, 16'(g));

      // ---- 5b: reset one Clk after gene rises ----
      chk("gene_before_rst", gene, 16'd1);
      Reset = 1'b1;
      @(negedge Clk);
      chk("rst_clears_gene", gene, 16'd0);
      chk("rst_state_wait", state_dbg, 16'd0);
      Reset = 1'b0;
      m_lfsr = 16'hACE1;
      m_prev = 16'hACE1;
      run_to_gene(130, idx);
      chk("gap_after_rst", idx, 16'd120);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
